// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared types for the fetch/data memory arbiter.
// Holds FSM state, transaction owner and counter width.
package rv32i_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return i_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rv32i_arb_pick.sv
// rv32i_arb_pick: combinational winner select between fetch and data.
// RV32I_ARB_ROUND_ROBIN_EN alternates the winner of contested requests.
module rv32i_arb_pick
    import rv32i_mem_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  owner_t i_last_winner,
    output logic   o_any,
    output owner_t o_winner
);

    logic w_contested;

    assign w_contested = i_if_req & i_d_req;

`ifdef RV32I_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_any    = i_if_req | i_d_req;
        o_winner = i_d_req ? OWN_D : OWN_IF;
        if (w_contested)
            o_winner = (i_last_winner == OWN_D) ? OWN_IF : OWN_D;
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_winner;

    // Fixed priority: data always beats fetch.
    always_comb begin
        o_any    = i_if_req | i_d_req;
        o_winner = OWN_IF;
        if (i_d_req || w_contested)
            o_winner = OWN_D;
    end
`endif

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: one-outstanding arbiter sharing a fixed-latency memory.
// Define RV32I_ARB_ROUND_ROBIN_EN for alternating priority on contention.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    owner_t           r_owner;
    logic             r_we;
    owner_t           w_last;
    owner_t           w_win;
    logic             w_any;
    logic             w_mis;
    logic             w_done;

    assign w_mis  = is_misaligned(d_addr[1:0]);
    assign w_done = (r_state == WAIT) && (r_cnt == LAT);

    rv32i_arb_pick u_pick (
        .i_if_req      (if_req),
        .i_d_req       (d_req),
        .i_last_winner (w_last),
        .o_any         (w_any),
        .o_winner      (w_win)
    );

`ifdef RV32I_ARB_ROUND_ROBIN_EN
    owner_t r_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= OWN_D;
        else if (r_state == IDLE && if_req && d_req)
            r_last <= w_win;
    end

    assign w_last = r_last;
`else
    assign w_last = OWN_D;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_owner <= w_win;
                r_we    <= (w_win == OWN_D) && d_we;
                r_cnt   <= CNT_W'(1);
            end else if (r_state == WAIT && !w_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_stall  = 1'b0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (w_any && w_win == OWN_D) begin
                        d_gnt = 1'b1;
                        if (w_mis) begin
                            w_next = ERR;
                        end else begin
                            w_next    = WAIT;
                            mem_req   = 1'b1;
                            mem_we    = d_we;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                        end
                    end else if (w_any) begin
                        w_next   = WAIT;
                        if_gnt   = 1'b1;
                        mem_req  = 1'b1;
                        mem_addr = if_addr;
                    end
                end
                WAIT: begin
                    if (w_done) begin
                        w_next = IDLE;
                        if (r_owner == OWN_D) begin
                            d_rvalid = 1'b1;
                            d_rdata  = r_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                    end
                end
                ERR: begin
                    w_next   = IDLE;
                    d_rvalid = 1'b1;
                    d_err    = 1'b1;
                end
                default: w_next = IDLE;
            endcase
            // Fetch stalls while waiting to be granted or while its access is in flight.
            if_stall = (if_req || (r_state == WAIT && r_owner == OWN_IF))
                       && !if_rvalid;
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: scoreboard bench for the fetch/data memory arbiter.
// Expected responses are queued at grant and popped on rvalid.
module tb_rv32i_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk;
    int n_err;
    int cyc;
    int g_if;
    int g_d;
    exp_t exp_if[$];
    exp_t exp_d[$];
    exp_t me;
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic [31:0] ra1;
    logic [31:0] ra2;

    rv32i_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int i);
        return (i == 0) ? 32'h00500093 : (32'hC0DE0000 | 32'(i));
    endfunction

    // Memory macro: read data valid LAT cycles after the request cycle.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (mem_req && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        ra1 <= mem_addr;
        ra2 <= ra1;
    end

    assign mem_rdata = mem[ra2[9:2]];

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at cyc %0d", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if_rvalid) begin
                if (exp_if.size() == 0) begin
                    chk("if_unexp", 1, 0);
                end else begin
                    me = exp_if.pop_front();
                    chk("if_rdata", if_rdata, me.data);
                    chk("if_lat", cyc, me.due);
                end
                chk("if_stall_rv", if_stall, 0);
                chk("d_rdata_nonown", d_rdata, 0);
            end
            if (d_rvalid) begin
                if (exp_d.size() == 0) begin
                    chk("d_unexp", 1, 0);
                end else begin
                    me = exp_d.pop_front();
                    chk("d_rdata", d_rdata, me.data);
                    chk("d_err", d_err, me.err);
                    chk("d_lat", cyc, me.due);
                end
                chk("if_rdata_nonown", if_rdata, 0);
            end
        end
    end

    task automatic rst_chk;
        chk("rst_outs", {if_gnt, if_rvalid, if_stall, d_gnt,
                         d_rvalid, d_err, mem_req, mem_we}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_mem", {mem_addr, mem_wdata}, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after all grants.
    task automatic issue(input bit fi, input logic [31:0] fa,
                         input bit fd, input bit we,
                         input logic [31:0] da, input logic [31:0] wd);
        bit pi;
        bit pd;
        int n;
        if_req  = fi;
        if_addr = fa;
        d_req   = fd;
        d_we    = we;
        d_addr  = da;
        d_wdata = wd;
        pi = fi;
        pd = fd;
        n  = 0;
        while ((pi || pd) && n < 40) begin
            @(negedge clk);
            n++;
            chk("one_gnt", {1'b0, if_gnt & d_gnt}, 0);
            if (if_gnt) begin
                g_if = cyc;
                chk("if_gnt_ok", {1'b0, pi}, 1);
                chk("if_mem", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, fa});
                chk("if_stall_gnt", if_stall, 1);
                exp_if.push_back('{ref_mem[fa[9:2]], 1'b0, cyc + LAT});
                pi = 1'b0;
            end
            if (d_gnt) begin
                g_d = cyc;
                chk("d_gnt_ok", {1'b0, pd}, 1);
                if (da[1:0] != 2'b00) begin
                    chk("d_mis_memreq", mem_req, 0);
                    exp_d.push_back('{32'h0, 1'b1, cyc + 1});
                end else begin
                    chk("d_mem", {mem_req, mem_we, mem_addr}, {1'b1, we, da});
                    if (we) begin
                        chk("d_wdata", mem_wdata, wd);
                        ref_mem[da[9:2]] = wd;
                        exp_d.push_back('{32'h0, 1'b0, cyc + LAT});
                    end else begin
                        exp_d.push_back('{ref_mem[da[9:2]], 1'b0, cyc + LAT});
                    end
                end
                pd = 1'b0;
            end
            @(posedge clk);
            #1;
            if_req = pi;
            d_req  = pd;
        end
        if (pi || pd) chk("gnt_timeout", 1, 0);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((exp_if.size() != 0 || exp_d.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_to", exp_if.size() + exp_d.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int op;
        logic [31:0] a;
        cyc     = 0;
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        repeat (2) begin
            @(negedge clk);
            rst_chk();
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-operation drops the in-flight load.
        d_req  = 1'b1;
        d_addr = 32'h40;
        @(negedge clk);
        chk("rmid_dgnt", d_gnt, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        rst   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            rst_chk();
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        t0  = cyc;
        issue(1, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rst_first_gnt", g_if, t0);
        drain();

        // Single fetch with stall profile.
        issue(1, 32'h0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("stall_t1", if_stall, 1);
        drain();
        @(negedge clk);
        chk("idle_mem", {mem_req, mem_we, mem_addr}, 0);
        chk("idle_stall", if_stall, 0);
        @(posedge clk);
        #1;

        // Contention: data first, fetch MEM_LATENCY+1 later.
        issue(1, 32'h4, 1, 0, 32'h100, 32'h0);
        chk("cont_order", g_if - g_d, LAT + 1);
        drain();

        // Store then load same word.
        issue(0, 32'h0, 1, 1, 32'h80, 32'hDEADBEEF);
        drain();
        issue(0, 32'h0, 1, 0, 32'h80, 32'h0);
        drain();

        // Misaligned load.
        issue(0, 32'h0, 1, 0, 32'h102, 32'h0);
        drain();

        // Misaligned load contending with fetch.
        issue(1, 32'h8, 1, 0, 32'h101, 32'h0);
        chk("mis_cont_order", g_if - g_d, 2);
        drain();

        for (int k = 0; k < 12; k++) begin
            op = int'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 63)) << 2;
            unique case (op)
                0: issue(1, a, 0, 0, 32'h0, 32'h0);
                1: issue(0, 32'h0, 1, 0, a, 32'h0);
                2: issue(0, 32'h0, 1, 1, a, $urandom);
                default: issue(1, a ^ 32'h4, 1, 0, a, 32'h0);
            endcase
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
